dep_eval_sched: RTL
===================

# dep_eval_sched

Round-robin scheduler that shares one registered evaluator of the function Result = a & (b | c) among N_REQ requesters. Each requester presents an {a,b,c} triple with a valid/ready handshake. The block arbitrates, evaluates the winning triple, and returns the result tagged with the requester index through a single-entry output buffer with backpressure. It sits between the requester agents and the downstream consumer in the dependence test design.

## Interface
- N_REQ, default 4: number of requesters, legal range 2..16.
- ID_W, default $clog2(N_REQ): width of the requester index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_abc  input  3*N_REQ  per-requester operands, packed {a,b,c}.
  - Requester i occupies bits [3i+2:3i]: a at 3i+2, b at 3i+1, c at 3i.
- req_ready  output  N_REQ  one-hot (or zero) accept strobe.
- rsp_valid  output  1  output buffer holds a result.
- rsp_ready  input  1  downstream accepts the result.
- rsp_id  output  ID_W  index of the requester that produced the result.
- rsp_result  output  1  a & (b | c) of the accepted triple.

## Operation
- Two-state FSM tracking the output buffer.
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- Accept condition: accept = (state==EMPTY) | (state==FULL & rsp_ready).
- Arbitration:
  - Round-robin pointer ptr (ID_W bits).
  - The winner is the first i with req_valid[i]=1, searching ptr, ptr+1, … modulo N_REQ.
  - req_ready[winner] = accept & any(req_valid); all other bits are 0.
  - req_ready is combinational from req_valid, state, ptr and rsp_ready.
- Handshake on requester i: req_valid[i] & req_ready[i] in the same cycle. On that edge:
  - rsp_result ← a&(b|c) of requester i.
  - rsp_id ← i.
  - ptr ← (i+1) mod N_REQ.
  - state ← FULL.
- Output drain:
  - rsp_valid & rsp_ready with no new handshake → EMPTY.
  - Drain with a simultaneous new handshake → stays FULL and loads the new result (throughput 1/cycle).
- While FULL and rsp_ready=0:
  - No req_ready is asserted.
  - rsp_id and rsp_result are held stable.
  - ptr does not change.
- ptr changes only on a handshake, never on idle cycles.
- Requesters must hold req_abc stable while req_valid=1. req_valid may deassert without a handshake; no state is affected.
- Wrap-around: a grant to N_REQ-1 sets ptr to 0.
- Reset (asynchronous, any time, including while FULL):
  - state=EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, ptr=0.
  - The held result is discarded.
  - req_ready is 0 while rst_n=0.

## Timing
- Latency: 1 cycle from the requester handshake edge to rsp_valid=1.
- Throughput: 1 result per cycle when rsp_ready is held at 1.
- Combinational path rsp_ready → req_ready is permitted and expected. There is no combinational path from req_abc to any output.
- Fairness: with all N_REQ requesters continuously valid and rsp_ready=1, each requester is granted exactly once every N_REQ cycles.
- First grant after reset deassertion can occur in the first cycle with rst_n=1.

## Configuration
- Macro: DEP_EVAL_SCHED_STATS_EN.
- With the macro defined, two extra output ports exist, both reset to 0 by rst_n:
  - stat_done  16  count of output handshakes (rsp_valid & rsp_ready).
  - stat_true  16  count of output handshakes where rsp_result=1.
  - Both counters saturate at 16'hFFFF and never wrap.
- Without the macro: the ports and counters are absent, and functional behaviour is otherwise identical.

## Structure
- Package dep_eval_sched_pkg contains:
  - The state enum {ST_EMPTY, ST_FULL}.
  - The function dep_eval(a,b,c) returning a&(b|c).
  - The localparam STAT_W=16.
- Sub-module dep_rr_arbiter:
  - Parameterised by N_REQ.
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant and binary grant index.
  - Purely combinational; ptr stays in the top level.

## Test plan
- Single request:
  - Stimulus: after reset, req_valid=4'b0100, requester 2 abc=3'b101, rsp_ready=1.
  - Response: req_ready=4'b0100 in that cycle; the next cycle rsp_valid=1, rsp_id=2, rsp_result=1, and ptr becomes 3.
- Full contention:
  - Stimulus: all four requesters valid, rsp_ready=1, held 8 cycles.
  - Response: rsp_id sequence 0,1,2,3,0,1,2,3.
- Backpressure:
  - Stimulus: rsp_ready=0 with the buffer FULL for 5 cycles while requesters are valid.
  - Response: req_ready=0 throughout and rsp_id/rsp_result stable; a single rsp_ready=1 cycle accepts the next winner in the same cycle.
- Truth table:
  - Stimulus: all 8 abc values through requester 1.
  - Response: rsp_result=1 only for abc ∈ {101, 110, 111}.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while FULL with rsp_id=3.
  - Response: rsp_valid, rsp_id and rsp_result drop to 0 immediately (asynchronously); after release, the first grant starts search from requester 0.
- Statistics (DEP_EVAL_SCHED_STATS_EN defined):
  - Stimulus: 10 drained results, 3 of them true.
  - Response: stat_done=10, stat_true=3.
  - Saturation: force 70000 handshakes; stat_done holds at 16'hFFFF.

Source files
------------

// File: rtl/dep_eval_sched_pkg.sv
// dep_eval_sched shared types: buffer state, evaluator function, stat width.
// Stats ports are enabled in the top by DEP_EVAL_SCHED_STATS_EN.
package dep_eval_sched_pkg;

  localparam int STAT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic dep_eval(
    input logic a,
    input logic b,
    input logic c
  );
    return a & (b | c);
  endfunction

endpackage

// File: rtl/dep_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr.
// The pointer register itself lives in the top level.
module dep_rr_arbiter
  import dep_eval_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_gidx
);

  localparam logic [ID_W:0] NR = (ID_W+1)'(N_REQ);

  logic            w_found;
  logic [ID_W:0]   w_sum;
  logic [ID_W-1:0] w_cand;

  always_comb begin
    w_found = 1'b0;
    o_gidx  = '0;
    o_grant = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
      if (w_sum >= NR) w_sum = w_sum - NR;
      w_cand = w_sum[ID_W-1:0];
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_gidx  = w_cand;
      end
    end
    if (i_en && w_found) o_grant[o_gidx] = 1'b1;
  end

endmodule

// File: rtl/dep_eval_sched.sv
// Round-robin shared a&(b|c) evaluator with a one-entry result buffer.
// Optional DEP_EVAL_SCHED_STATS_EN adds saturating stat_done/stat_true.
module dep_eval_sched
  import dep_eval_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [3*N_REQ-1:0] req_abc,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_result
`ifdef DEP_EVAL_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_done,
  output logic [STAT_W-1:0]  stat_true
`endif
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_id;
  logic            r_res;
  logic            w_accept;
  logic            w_hs;
  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0] w_gidx;
  logic [ID_W-1:0] w_ptr_nxt;
  logic [2:0]      w_abc;

  // Gating with rst_n keeps req_ready low for the whole reset.
  assign w_accept = rst_n & ((r_state == ST_EMPTY) | rsp_ready);

  dep_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_accept),
    .o_grant (w_grant),
    .o_gidx  (w_gidx)
  );

  assign req_ready  = w_grant;
  assign w_hs       = |w_grant;
  assign rsp_valid  = (r_state == ST_FULL);
  assign rsp_id     = r_id;
  assign rsp_result = r_res;

  always_comb begin
    w_abc = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gidx == ID_W'(i)) w_abc = req_abc[3*i +: 3];
    end
  end

  always_comb begin
    if (w_gidx == ID_W'(N_REQ-1)) w_ptr_nxt = '0;
    else                          w_ptr_nxt = w_gidx + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_hs) w_state_nxt = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_hs) w_state_nxt = ST_EMPTY;
      default:  w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_id  <= '0;
      r_res <= 1'b0;
    end else if (w_hs) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_gidx;
      r_res <= dep_eval(w_abc[2], w_abc[1], w_abc[0]);
    end
  end

`ifdef DEP_EVAL_SCHED_STATS_EN
  logic [STAT_W-1:0] r_done;
  logic [STAT_W-1:0] r_true;
  logic              w_drain;

  assign w_drain   = rsp_valid & rsp_ready;
  assign stat_done = r_done;
  assign stat_true = r_true;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= '0;
      r_true <= '0;
    end else if (w_drain) begin
      if (r_done != '1)          r_done <= r_done + 1'b1;
      if (r_res && r_true != '1) r_true <= r_true + 1'b1;
    end
  end
`endif

endmodule
